// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the ID-stage hazard stall unit.
//   REG_AW       : default register address width
//   ZERO_REG     : the hard-wired zero register, which never creates a hazard
//   stateT       : stall FSM state (RUN = normal issue, HOLD = forced 2nd stall cycle)
//   stallCauseT  : encoded stall cause, ordered by priority
//   stallPriority: resolves simultaneous hazards to a single cause (BL wins)
package hazard_stall_unit_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } stateT;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_BM   = 3'd1,
    CAUSE_BA   = 3'd2,
    CAUSE_LU   = 3'd3,
    CAUSE_BL   = 3'd4
  } stallCauseT;

  // BL needs two cycles, so it must win over the one-cycle causes
  // that usually fire alongside it (a branch on a load is also a load-use).
  function automatic stallCauseT stallPriority(input logic lu, input logic ba,
                                               input logic bl, input logic bm);
    stallCauseT c;
    c = CAUSE_NONE;
    if (bl)      c = CAUSE_BL;
    else if (lu) c = CAUSE_LU;
    else if (ba) c = CAUSE_BA;
    else if (bm) c = CAUSE_BM;
    return c;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// Saturating up-counter.
//   clk   : rising-edge clock
//   reset : synchronous active-high clear
//   inc   : add one on this edge (ignored once the counter is full)
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage stall/flush unit: handles hazards that EX forwarding cannot cover
// (load-use, and branches whose operands are compared in ID).
//   clk, reset           : clock and synchronous active-high reset
//   IF_ID_RegisterRs/Rt  : sources of the ID instruction; UsesRt_ID qualifies rt
//   Branch_ID, BranchTaken_ID, Jump_ID : control-flow info of the ID instruction
//   ID_EX_*              : load / register-write / destination of the EX instruction
//   EX_MEM_*             : load / destination of the MEM instruction
//   PCWrite, IF_ID_Write : front-end enables, low while stalling
//   ID_EX_Bubble         : zero the ID/EX control word this cycle
//   IF_ID_Flush          : squash the fetched instruction after a taken branch/jump
//   stall_cycles         : saturating count of stalled cycles since reset
module hazard_stall_unit #(
  parameter int REG_AW = hazard_stall_unit_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] IF_ID_RegisterRs,
  input  logic [REG_AW-1:0] IF_ID_RegisterRt,
  input  logic              UsesRt_ID,
  input  logic              Branch_ID,
  input  logic              BranchTaken_ID,
  input  logic              Jump_ID,
  input  logic              ID_EX_MemRead,
  input  logic              ID_EX_RegWrite,
  input  logic [REG_AW-1:0] ID_EX_RegisterRd,
  input  logic              EX_MEM_MemRead,
  input  logic [REG_AW-1:0] EX_MEM_RegisterRd,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              ID_EX_Bubble,
  output logic              IF_ID_Flush,
  output logic [CNT_W-1:0]  stall_cycles
);

  import hazard_stall_unit_pkg::*;

  stateT      state;
  stateT      stateNext;
  stallCauseT cause;
  logic       matchEx;
  logic       matchMem;
  logic       lu;
  logic       ba;
  logic       bl;
  logic       bm;
  logic       stall;

  function automatic logic regMatch(input logic [REG_AW-1:0] d,
                                    input logic [REG_AW-1:0] rs,
                                    input logic [REG_AW-1:0] rt,
                                    input logic              usesRt);
    return (d != REG_AW'(ZERO_REG)) && ((d == rs) || (usesRt && (d == rt)));
  endfunction

  assign matchEx  = regMatch(ID_EX_RegisterRd,  IF_ID_RegisterRs, IF_ID_RegisterRt, UsesRt_ID);
  assign matchMem = regMatch(EX_MEM_RegisterRd, IF_ID_RegisterRs, IF_ID_RegisterRt, UsesRt_ID);

  assign lu = ID_EX_MemRead & matchEx;
  assign ba = Branch_ID & ID_EX_RegWrite & ~ID_EX_MemRead & matchEx;
  assign bl = Branch_ID & ID_EX_MemRead & matchEx;
  assign bm = Branch_ID & EX_MEM_MemRead & matchMem;

  assign cause = stallPriority(lu, ba, bl, bm);

  // HOLD covers the cycle where the load has moved to MEM and EX holds our
  // bubble; the comparator operands are still not ready, so the stall is forced.
  always_comb begin
    stall     = 1'b0;
    stateNext = state;
    if (!reset) begin
      if (state == HOLD) begin
        stall     = 1'b1;
        stateNext = RUN;
      end else begin
        stall = (cause != CAUSE_NONE);
        if (cause == CAUSE_BL) stateNext = HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= stateNext;
  end

  assign PCWrite      = ~stall;
  assign IF_ID_Write  = ~stall;
  assign ID_EX_Bubble = stall;
  // A stalled branch has unresolved operands, so its outcome cannot flush yet.
  assign IF_ID_Flush  = ~reset & ~stall & (Jump_ID | (Branch_ID & BranchTaken_ID));

  sat_counter #(
    .CNT_W(CNT_W)
  ) uStallCnt (
    .clk  (clk),
    .reset(reset),
    .inc  (stall),
    .count(stall_cycles)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          usesRt;
    logic          br;
    logic          taken;
    logic          jmp;
    logic          exMr;
    logic          exRw;
    logic [AW-1:0] exRd;
    logic          memMr;
    logic [AW-1:0] memRd;
  } stimT;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs, rt, exRd, memRd;
  logic          usesRt, br, taken, jmp, exMr, exRw, memMr;
  logic          pcWrite, ifIdWrite, bubble, flush;
  logic [CW-1:0] stallCycles;

  int checks = 0;
  int errors = 0;

  // Reference model: number of extra forced stall cycles still owed, and the count.
  int       holdLeft = 0;
  int       modelCnt = 0;
  bit       expStall;
  bit       expBl;
  logic [3:0] expOut;

  always #5 clk = ~clk;

  hazard_stall_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (rst),
    .IF_ID_RegisterRs (rs),
    .IF_ID_RegisterRt (rt),
    .UsesRt_ID        (usesRt),
    .Branch_ID        (br),
    .BranchTaken_ID   (taken),
    .Jump_ID          (jmp),
    .ID_EX_MemRead    (exMr),
    .ID_EX_RegWrite   (exRw),
    .ID_EX_RegisterRd (exRd),
    .EX_MEM_MemRead   (memMr),
    .EX_MEM_RegisterRd(memRd),
    .PCWrite          (pcWrite),
    .IF_ID_Write      (ifIdWrite),
    .ID_EX_Bubble     (bubble),
    .IF_ID_Flush      (flush),
    .stall_cycles     (stallCycles)
  );

  task automatic applyStim(input stimT s);
    rst = s.rst; rs = s.rs; rt = s.rt; usesRt = s.usesRt; br = s.br; taken = s.taken;
    jmp = s.jmp; exMr = s.exMr; exRw = s.exRw; exRd = s.exRd; memMr = s.memMr; memRd = s.memRd;
  endtask

  function automatic bit hits(input int d, input int srcS, input int srcT, input bit useT);
    return (d != 0) && ((d == srcS) || (useT && (d == srcT)));
  endfunction

  // Expected outputs as {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush}.
  task automatic modelEval(input stimT s);
    bit hEx, hMem, hazard;
    hEx    = hits(int'(s.exRd),  int'(s.rs), int'(s.rt), s.usesRt);
    hMem   = hits(int'(s.memRd), int'(s.rs), int'(s.rt), s.usesRt);
    expBl  = s.br && s.exMr && hEx;
    hazard = (s.exMr && hEx) || (s.br && s.exRw && !s.exMr && hEx) || expBl ||
             (s.br && s.memMr && hMem);
    if (s.rst) begin
      expStall = 1'b0;
      expOut   = 4'b1100;
    end else begin
      expStall = (holdLeft > 0) || hazard;
      if (expStall) expOut = 4'b0010;
      else          expOut = {3'b110, (s.jmp || (s.br && s.taken))};
    end
  endtask

  task automatic modelAdvance(input stimT s);
    if (s.rst) begin
      holdLeft = 0;
      modelCnt = 0;
    end else begin
      if (expStall) modelCnt = (modelCnt < CMAX) ? modelCnt + 1 : CMAX;
      if (holdLeft > 0) holdLeft = holdLeft - 1;
      else if (expBl)   holdLeft = 1;
    end
  endtask

  function automatic stimT randStim(input bit allowRst);
    stimT s;
    s        = '0;
    s.rst    = allowRst && ($urandom_range(0, 29) == 0);
    s.rs     = AW'($urandom_range(0, 3));
    s.rt     = AW'($urandom_range(0, 3));
    s.usesRt = 1'($urandom);
    s.br     = 1'($urandom);
    s.taken  = 1'($urandom);
    s.jmp    = ($urandom_range(0, 5) == 0);
    s.exMr   = 1'($urandom);
    s.exRw   = 1'($urandom);
    s.exRd   = AW'($urandom_range(0, 3));
    s.memMr  = 1'($urandom);
    s.memRd  = AW'($urandom_range(0, 3));
    return s;
  endfunction

  task automatic test_reset();
    stimT s;
    s = '0; s.rst = 1'b1;
    applyStim(s);
    @(posedge clk); #1;
    modelAdvance(s);
    // Reset still high with a live load-use hazard on the inputs.
    s.exMr = 1'b1; s.exRd = 5'd8; s.rs = 5'd8;
    applyStim(s);
    @(negedge clk); modelEval(s);
    checks++;
    if ({pcWrite, ifIdWrite, bubble, flush} !== 4'b1100) begin
      errors++; $display("FAIL reset_ctrl got %b want %b", {pcWrite, ifIdWrite, bubble, flush}, 4'b1100);
    end
    @(posedge clk); #1; modelAdvance(s);
    checks++;
    if (stallCycles !== '0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", stallCycles);
    end
  endtask

  task automatic test_load_use();
    stimT q[$];
    stimT s;
    int   c0;
    c0 = modelCnt;
    s = '0; s.exMr = 1'b1; s.exRd = 5'd8; s.rs = 5'd8; q.push_back(s);
    s = '0; s.rs = 5'd8; q.push_back(s);
    for (int i = 0; i < q.size(); i++) begin
      applyStim(q[i]);
      @(negedge clk); modelEval(q[i]);
      checks++;
      if ({pcWrite, ifIdWrite, bubble, flush} !== expOut) begin
        errors++; $display("FAIL load_use[%0d] ctrl got %b want %b", i, {pcWrite, ifIdWrite, bubble, flush}, expOut);
      end
      @(posedge clk); #1; modelAdvance(q[i]);
    end
    checks++;
    if (int'(stallCycles) !== c0 + 1) begin
      errors++; $display("FAIL load_use_cnt got %0d want %0d", stallCycles, c0 + 1);
    end
  endtask

  task automatic test_branch_load();
    stimT q[$];
    stimT s;
    int   c0;
    int   stalls;
    c0 = modelCnt; stalls = 0;
    s = '0; s.br = 1'b1; s.rs = 5'd9; s.exMr = 1'b1; s.exRd = 5'd9; s.taken = 1'b1; q.push_back(s);
    s = '0; s.br = 1'b1; s.rs = 5'd9; s.taken = 1'b1; q.push_back(s);
    s = '0; q.push_back(s);
    for (int i = 0; i < q.size(); i++) begin
      applyStim(q[i]);
      @(negedge clk); modelEval(q[i]);
      if (bubble === 1'b1) stalls++;
      checks++;
      if ({pcWrite, ifIdWrite, bubble, flush} !== expOut || (i < 2 && flush !== 1'b0)) begin
        errors++; $display("FAIL branch_load[%0d] ctrl got %b want %b", i, {pcWrite, ifIdWrite, bubble, flush}, expOut);
      end
      @(posedge clk); #1; modelAdvance(q[i]);
    end
    checks++;
    if (stalls != 2 || int'(stallCycles) !== c0 + 2) begin
      errors++; $display("FAIL branch_load_len stalls %0d cnt %0d want 2 and %0d", stalls, stallCycles, c0 + 2);
    end
  endtask

  task automatic test_branch_alu_taken();
    stimT q[$];
    stimT s;
    s = '0; s.br = 1'b1; s.rs = 5'd10; s.exRw = 1'b1; s.exRd = 5'd10; q.push_back(s);
    s = '0; s.br = 1'b1; s.rs = 5'd10; s.taken = 1'b1; q.push_back(s);
    s = '0; q.push_back(s);
    for (int i = 0; i < q.size(); i++) begin
      applyStim(q[i]);
      @(negedge clk); modelEval(q[i]);
      checks++;
      if ({pcWrite, ifIdWrite, bubble, flush} !== expOut) begin
        errors++; $display("FAIL branch_alu[%0d] ctrl got %b want %b", i, {pcWrite, ifIdWrite, bubble, flush}, expOut);
      end
      @(posedge clk); #1; modelAdvance(q[i]);
    end
  endtask

  task automatic test_reg_zero();
    stimT q[$];
    stimT s;
    s = '0; s.exMr = 1'b1; s.exRd = 5'd0; s.rs = 5'd0; s.br = 1'b1; q.push_back(s);
    s = '0; s.exMr = 1'b1; s.exRd = 5'd7; s.rs = 5'd3; s.rt = 5'd7; s.usesRt = 1'b0; q.push_back(s);
    s = '0; s.br = 1'b1; s.memMr = 1'b1; s.memRd = 5'd0; q.push_back(s);
    for (int i = 0; i < q.size(); i++) begin
      applyStim(q[i]);
      @(negedge clk); modelEval(q[i]);
      checks++;
      if ({pcWrite, ifIdWrite, bubble, flush} !== 4'b1100) begin
        errors++; $display("FAIL reg_zero[%0d] ctrl got %b want %b", i, {pcWrite, ifIdWrite, bubble, flush}, 4'b1100);
      end
      @(posedge clk); #1; modelAdvance(q[i]);
    end
  endtask

  task automatic test_reset_in_hold();
    stimT q[$];
    stimT s;
    s = '0; s.br = 1'b1; s.rs = 5'd4; s.exMr = 1'b1; s.exRd = 5'd4; q.push_back(s);
    s = '0; s.rst = 1'b1; q.push_back(s);
    s = '0; q.push_back(s);
    for (int i = 0; i < q.size(); i++) begin
      applyStim(q[i]);
      @(negedge clk); modelEval(q[i]);
      checks++;
      if ({pcWrite, ifIdWrite, bubble, flush} !== expOut) begin
        errors++; $display("FAIL reset_hold[%0d] ctrl got %b want %b", i, {pcWrite, ifIdWrite, bubble, flush}, expOut);
      end
      @(posedge clk); #1; modelAdvance(q[i]);
      checks++;
      if (int'(stallCycles) !== modelCnt) begin
        errors++; $display("FAIL reset_hold_cnt[%0d] got %0d want %0d", i, stallCycles, modelCnt);
      end
    end
  endtask

  task automatic test_saturation();
    stimT s;
    s = '0; s.rst = 1'b1;
    applyStim(s); @(negedge clk); modelEval(s); @(posedge clk); #1; modelAdvance(s);
    s = '0; s.exMr = 1'b1; s.exRd = 5'd12; s.rt = 5'd12; s.usesRt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStim(s);
      @(negedge clk); modelEval(s);
      @(posedge clk); #1; modelAdvance(s);
      checks++;
      if (int'(stallCycles) !== modelCnt) begin
        errors++; $display("FAIL saturation[%0d] got %0d want %0d", i, stallCycles, modelCnt);
      end
    end
    checks++;
    if (stallCycles !== 4'd15) begin
      errors++; $display("FAIL saturation_final got %0d want 15", stallCycles);
    end
  endtask

  task automatic test_random();
    stimT s;
    for (int i = 0; i < 400; i++) begin
      s = randStim(1'b1);
      applyStim(s);
      @(negedge clk); modelEval(s);
      checks++;
      if ({pcWrite, ifIdWrite, bubble, flush} !== expOut) begin
        errors++; $display("FAIL random[%0d] ctrl got %b want %b", i, {pcWrite, ifIdWrite, bubble, flush}, expOut);
      end
      @(posedge clk); #1; modelAdvance(s);
      checks++;
      if (int'(stallCycles) !== modelCnt) begin
        errors++; $display("FAIL random_cnt[%0d] got %0d want %0d", i, stallCycles, modelCnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu_taken();
    test_reg_zero();
    test_reset_in_hold();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
